mesh_term_ingress_bank: RTL and testbench
=========================================

Name: mesh_term_ingress_bank

Overview:
- Bank of NTERM independent show-ahead FIFOs, one per mesh terminal.
- Sits between the terminal-side agents/drivers and the mesh_gnrtr terminal inputs.
- Each channel buffers packets and presents them to the router through pndng_i_in/data_out_i_in; the router pops with popin.
- Generalises the single-depth per-terminal feed with per-channel occupancy, a selectable full policy (backpressure or overwrite-oldest) and sticky error flags.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- NTERM, ROWS*2+COLUMS*2, number of terminal channels.
- pckg_sz, 41, packet width in bits.
- fifo_depth, 8, entries per channel; power of two, >=2.
- OVERWRITE, 0, full policy: 0 = backpressure/drop-new, 1 = overwrite-oldest.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  NTERM  per-channel write strobe from agent/driver.
- data_in  in  NTERM*pckg_sz  write data; channel i at [i*pckg_sz +: pckg_sz].
- full  out  NTERM  channel holds fifo_depth entries.
- popin  in  NTERM  router pops head of channel i.
- pndng_i_in  out  NTERM  channel non-empty; head valid.
- data_out_i_in  out  NTERM*pckg_sz  head entry per channel, same packing as data_in.
- count  out  NTERM*$clog2(fifo_depth+1)  per-channel occupancy.
- err_ovf  out  NTERM  sticky: push lost or overwrote data.
- err_udf  out  NTERM  sticky: popin while empty.
- drop_cnt  out  16  total dropped/overwritten packets (see Optional Feature).

Behaviour:
- One clock; synchronous active-high reset. Channels are fully independent.
- Reset (any cycle, including mid-transfer): rd/wr pointers and count = 0; pndng_i_in = 0; data_out_i_in = 0; full = 0; err_ovf = err_udf = 0; drop_cnt = 0. Stored contents are discarded. Push/pop in the reset cycle are ignored.
- Show-ahead: pndng_i_in[i] = (count[i] != 0). data_out_i_in[i] = mem[rd_ptr] when non-empty, 0 when empty. Registered state, combinational read of head.
- Latency: push sampled at edge k into an empty channel gives pndng_i_in = 1 and valid head from edge k onward (visible the cycle after the push).
- Pop: popin[i] with pndng_i_in[i] = 1 retires the head at the edge. The next entry (or empty) is presented after that edge.
- Pointers wrap modulo fifo_depth; count is 0..fifo_depth; full = (count == fifo_depth).
- Push, not full: write at wr_ptr, wr_ptr++, count++.
- Pop, non-empty, no push: rd_ptr++, count--.
- Push and pop, non-empty: both pointers advance; count unchanged. This applies when full, in both policies, with no drop.
- Push and pop, empty: push is stored; pop is an underflow (err_udf set); count becomes 1.
- Push when full, no pop, OVERWRITE=0: data discarded; pointers and count unchanged; err_ovf set; drop event.
- Push when full, no pop, OVERWRITE=1: oldest entry discarded (rd_ptr++), new entry written (wr_ptr++); count stays fifo_depth; err_ovf set; drop event.
- Pop when empty, no push: no state change except err_udf set.
- Error flags clear only on reset.
- Packet contents are never inspected or modified; broadcast packets pass through unchanged.

Optional Feature:
- Macro: MESH_INGRESS_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit saturating counter (stops at 16'hFFFF) of drop events summed across channels per cycle. It adds the number of channels with a drop event that cycle; multiple simultaneous drops add their count.
- Not defined: drop_cnt is tied to 16'h0000 and no counter logic is built. err_ovf is unaffected.

Test Plan:
- Reset then idle -> all outputs 0; count = 0 on all 16 channels.
- Channel 3: push 41'h0_0123_4567 then 41'h1_89AB_CDEF on consecutive cycles, no pop -> pndng_i_in[3] = 1 one cycle after the first push; head = 41'h0_0123_4567; count = 2. popin[3] one cycle -> head = 41'h1_89AB_CDEF; count = 1.
- OVERWRITE=0, channel 0: push 9 packets (values 1..9) with no pop -> full = 1 after the 8th; 9th dropped; err_ovf[0] = 1; drop_cnt = 1 with macro. Drain -> outputs 1..8 in order.
- OVERWRITE=1, channel 0: same 9 pushes -> count stays 8; err_ovf[0] = 1. Drain -> outputs 2..9.
- Channel 5 full: push 8'hAA-tagged packet and popin on the same cycle -> count stays 8; no err_ovf; drop_cnt unchanged. Popin on empty channel 7 -> err_udf[7] = 1; count = 0.
- Channels 2 and 4 holding 3 entries each, assert reset for 1 cycle mid-stream -> all counts 0; pndng_i_in = 0; error flags and drop_cnt cleared the next cycle.

Source files
------------

// File: rtl/mesh_term_ingress_bank.sv
// Bank of NTERM independent show-ahead FIFOs feeding the mesh terminal inputs.
// Optional macro MESH_INGRESS_DROP_CNT_EN builds the saturating drop counter on drop_cnt.
module mesh_term_ingress_bank #(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int NTERM      = ROWS*2 + COLUMS*2,
    parameter int pckg_sz    = 41,
    parameter int fifo_depth = 8,
    parameter int OVERWRITE  = 0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NTERM-1:0]                             push,
    input  logic [NTERM*pckg_sz-1:0]                     data_in,
    output logic [NTERM-1:0]                             full,
    input  logic [NTERM-1:0]                             popin,
    output logic [NTERM-1:0]                             pndng_i_in,
    output logic [NTERM*pckg_sz-1:0]                     data_out_i_in,
    output logic [NTERM*$clog2(fifo_depth+1)-1:0]        count,
    output logic [NTERM-1:0]                             err_ovf,
    output logic [NTERM-1:0]                             err_udf,
    output logic [15:0]                                  drop_cnt
);

    localparam int CW = $clog2(fifo_depth + 1);
    localparam int PW = $clog2(fifo_depth);
    localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);

    logic [NTERM-1:0] drop;

    for (genvar i = 0; i < NTERM; i++) begin : g_chan
        logic [pckg_sz-1:0] mem [fifo_depth];
        logic [PW-1:0]      rd_ptr, wr_ptr;
        logic [CW-1:0]      cnt;
        logic               ovf_q, udf_q;
        logic               is_full, is_empty, pop_ok, adv_wr, adv_rd;

        assign is_full  = (cnt == DEPTH);
        assign is_empty = (cnt == '0);
        assign pop_ok   = popin[i] && !is_empty;
        // A full channel still accepts a push when the head leaves this cycle or when overwriting.
        assign adv_wr   = push[i] && (!is_full || pop_ok || (OVERWRITE != 0));
        assign adv_rd   = pop_ok || (push[i] && is_full && (OVERWRITE != 0));
        assign drop[i]  = push[i] && is_full && !popin[i];

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (adv_wr)
                    wr_ptr <= wr_ptr + 1'b1;
                if (adv_rd)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push[i] && !is_full && !pop_ok)
                    cnt <= cnt + 1'b1;
                else if (pop_ok && !push[i])
                    cnt <= cnt - 1'b1;
                if (drop[i])
                    ovf_q <= 1'b1;
                if (popin[i] && is_empty)
                    udf_q <= 1'b1;
            end
        end

        // Storage is not reset; the empty check masks stale entries on the head output.
        always_ff @(posedge clk) begin
            if (adv_wr && !reset)
                mem[wr_ptr] <= data_in[i*pckg_sz +: pckg_sz];
        end

        assign full[i]                             = is_full;
        assign pndng_i_in[i]                       = !is_empty;
        assign data_out_i_in[i*pckg_sz +: pckg_sz] = is_empty ? '0 : mem[rd_ptr];
        assign count[i*CW +: CW]                   = cnt;
        assign err_ovf[i]                          = ovf_q;
        assign err_udf[i]                          = udf_q;
    end

`ifdef MESH_INGRESS_DROP_CNT_EN
    logic [15:0] drop_q;
    logic [15:0] ndrop;
    logic [16:0] sum;

    always_comb begin
        ndrop = '0;
        for (int j = 0; j < NTERM; j++)
            ndrop = ndrop + 16'(drop[j]);
        sum = {1'b0, drop_q} + {1'b0, ndrop};
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_q <= '0;
        else
            drop_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mesh_term_ingress_bank.sv
// Directed bench for mesh_term_ingress_bank: one backpressure and one overwrite instance share stimulus.
module tb_mesh_term_ingress_bank;

    localparam int NT = 16;
    localparam int PK = 41;
    localparam int CW = 4;

`ifdef MESH_INGRESS_DROP_CNT_EN
    localparam int DROP_ONE = 1;
`else
    localparam int DROP_ONE = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     push, popin;
    logic [NT*PK-1:0]  data_in;

    logic [NT-1:0]     full0, pndng0, ovf0, udf0;
    logic [NT*PK-1:0]  dout0;
    logic [NT*CW-1:0]  count0;
    logic [15:0]       drop0;

    logic [NT-1:0]     full1, pndng1, ovf1, udf1;
    logic [NT*PK-1:0]  dout1;
    logic [NT*CW-1:0]  count1;
    logic [15:0]       drop1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mesh_term_ingress_bank #(.ROWS(4), .COLUMS(4), .pckg_sz(PK), .fifo_depth(8), .OVERWRITE(0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full0),
        .popin(popin), .pndng_i_in(pndng0), .data_out_i_in(dout0), .count(count0),
        .err_ovf(ovf0), .err_udf(udf0), .drop_cnt(drop0));

    mesh_term_ingress_bank #(.ROWS(4), .COLUMS(4), .pckg_sz(PK), .fifo_depth(8), .OVERWRITE(1)) dut1 (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full1),
        .popin(popin), .pndng_i_in(pndng1), .data_out_i_in(dout1), .count(count1),
        .err_ovf(ovf1), .err_udf(udf1), .drop_cnt(drop1));

    function automatic logic [PK-1:0] head0(input int ch);
        return dout0[ch*PK +: PK];
    endfunction

    function automatic logic [PK-1:0] head1(input int ch);
        return dout1[ch*PK +: PK];
    endfunction

    function automatic logic [CW-1:0] cnt0(input int ch);
        return count0[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] cnt1(input int ch);
        return count1[ch*CW +: CW];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, let the edge happen, then sample 1 time unit later.
    task automatic applyStimulus(input logic [NT-1:0] p, input logic [NT-1:0] q,
                                 input int ch, input logic [PK-1:0] d);
        push    = p;
        popin   = q;
        data_in = '0;
        data_in[ch*PK +: PK] = d;
        @(posedge clk);
        #1;
        push    = '0;
        popin   = '0;
        data_in = '0;
    endtask

    initial begin
        reset   = 1'b1;
        push    = '0;
        popin   = '0;
        data_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus('0, '0, 0, '0);

        checkOutput("rst_pndng",  {48'd0, pndng0}, 64'h0);
        checkOutput("rst_full",   {48'd0, full0},  64'h0);
        checkOutput("rst_dout",   {63'd0, |dout0}, 64'h0);
        checkOutput("rst_count",  count0,          64'h0);
        checkOutput("rst_ovf",    {48'd0, ovf0},   64'h0);
        checkOutput("rst_udf",    {48'd0, udf0},   64'h0);
        checkOutput("rst_drop",   {48'd0, drop0},  64'h0);
        checkOutput("rst_count1", count1,          64'h0);

        applyStimulus(16'h0008, '0, 3, 41'h0_0123_4567);
        checkOutput("c3_pndng",  {48'd0, pndng0}, 64'h0008);
        checkOutput("c3_head1",  {23'd0, head0(3)}, 64'h0_0123_4567);
        checkOutput("c3_cnt1",   {60'd0, cnt0(3)}, 64'd1);
        applyStimulus(16'h0008, '0, 3, 41'h1_89AB_CDEF);
        checkOutput("c3_cnt2",   {60'd0, cnt0(3)}, 64'd2);
        checkOutput("c3_head2",  {23'd0, head0(3)}, 64'h0_0123_4567);
        applyStimulus('0, 16'h0008, 0, '0);
        checkOutput("c3_headpop", {23'd0, head0(3)}, 64'h1_89AB_CDEF);
        checkOutput("c3_cntpop",  {60'd0, cnt0(3)}, 64'd1);
        applyStimulus('0, 16'h0008, 0, '0);
        checkOutput("c3_empty",   {63'd0, pndng0[3]}, 64'd0);
        checkOutput("c3_zerohd",  {23'd0, head0(3)}, 64'd0);

        for (int v = 1; v <= 9; v++) begin
            applyStimulus(16'h0001, '0, 0, PK'(v));
            if (v == 8) begin
                checkOutput("c0_full_bp", {63'd0, full0[0]}, 64'd1);
                checkOutput("c0_full_ow", {63'd0, full1[0]}, 64'd1);
                checkOutput("c0_noovf",   {63'd0, ovf0[0]},  64'd0);
            end
        end
        checkOutput("c0_cnt_bp",  {60'd0, cnt0(0)}, 64'd8);
        checkOutput("c0_cnt_ow",  {60'd0, cnt1(0)}, 64'd8);
        checkOutput("c0_ovf_bp",  {48'd0, ovf0},    64'h0001);
        checkOutput("c0_ovf_ow",  {48'd0, ovf1},    64'h0001);
        checkOutput("c0_drop_bp", {48'd0, drop0},   64'(DROP_ONE));
        checkOutput("c0_drop_ow", {48'd0, drop1},   64'(DROP_ONE));
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("c0_drain_bp%0d", k), {23'd0, head0(0)}, 64'(k));
            checkOutput($sformatf("c0_drain_ow%0d", k), {23'd0, head1(0)}, 64'(k + 1));
            applyStimulus('0, 16'h0001, 0, '0);
        end
        checkOutput("c0_empty_bp", {63'd0, pndng0[0]}, 64'd0);
        checkOutput("c0_empty_ow", {63'd0, pndng1[0]}, 64'd0);

        for (int k = 0; k < 8; k++)
            applyStimulus(16'h0020, '0, 5, PK'(8'h50 + k));
        checkOutput("c5_full", {63'd0, full0[5]}, 64'd1);
        applyStimulus(16'h0020, 16'h0020, 5, 41'h0AA);
        checkOutput("c5_cnt_bp",  {60'd0, cnt0(5)}, 64'd8);
        checkOutput("c5_cnt_ow",  {60'd0, cnt1(5)}, 64'd8);
        checkOutput("c5_ovf_bp",  {48'd0, ovf0},    64'h0001);
        checkOutput("c5_ovf_ow",  {48'd0, ovf1},    64'h0001);
        checkOutput("c5_drop",    {48'd0, drop0},   64'(DROP_ONE));
        checkOutput("c5_head",    {23'd0, head0(5)}, 64'h51);

        applyStimulus('0, 16'h0080, 0, '0);
        checkOutput("c7_udf",  {48'd0, udf0},     64'h0080);
        checkOutput("c7_cnt",  {60'd0, cnt0(7)},  64'd0);
        applyStimulus(16'h0040, 16'h0040, 6, 41'h1_2345_6789);
        checkOutput("c6_udf",  {48'd0, udf0},     64'h00C0);
        checkOutput("c6_cnt",  {60'd0, cnt0(6)},  64'd1);
        checkOutput("c6_head", {23'd0, head0(6)}, 64'h1_2345_6789);

        for (int k = 0; k < 3; k++)
            applyStimulus(16'h0014, '0, 2, PK'(k + 1));
        checkOutput("c2_cnt", {60'd0, cnt0(2)}, 64'd3);
        checkOutput("c4_cnt", {60'd0, cnt0(4)}, 64'd3);
        reset = 1'b1;
        applyStimulus(16'h0014, 16'h0004, 2, 41'h7);
        reset = 1'b0;
        checkOutput("mid_count",  count0,          64'h0);
        checkOutput("mid_count1", count1,          64'h0);
        checkOutput("mid_pndng",  {48'd0, pndng0}, 64'h0);
        checkOutput("mid_ovf",    {48'd0, ovf0},   64'h0);
        checkOutput("mid_udf",    {48'd0, udf0},   64'h0);
        checkOutput("mid_drop",   {48'd0, drop0},  64'h0);
        checkOutput("mid_dout",   {63'd0, |dout0}, 64'h0);
        applyStimulus(16'h0004, '0, 2, 41'h1_0000_0001);
        checkOutput("post_head",  {23'd0, head0(2)}, 64'h1_0000_0001);
        checkOutput("post_cnt",   {60'd0, cnt0(2)},  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
